// File: rtl/hid_pkg.sv
// Shared types and constants for the HID event hub: event layout, bus word map, STATUS/DATA bit positions.
package hid_pkg;

  // One captured scan event: break flag above the 8-bit scan code.
  typedef struct packed {
    logic       released;
    logic [7:0] code;
  } hid_event_t;

  // Each channel owns two consecutive words; CTRL sits right after the last channel.
  localparam int WORDS_PER_CHAN  = 2;
  localparam int WORD_DATA_OFS   = 0;
  localparam int WORD_STATUS_OFS = 1;

  // STATUS fields.
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_FLUSH_BIT = 20;

  // DATA word flag marking a valid popped entry.
  localparam int DATA_VALID_BIT = 63;

  // Word index of CTRL for a given channel count.
  function automatic int ctrl_word(input int nchan);
    return WORDS_PER_CHAN * nchan;
  endfunction

endpackage

// File: rtl/hid_chan_fifo.sv
// Per-channel synchronous event FIFO with flush and overflow reporting.
// Pops on an empty FIFO are ignored, so an empty FIFO never falls through.
module hid_chan_fifo
  import hid_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  hid_event_t    din,
  output hid_event_t    dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf_set
);

  hid_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  // Flush discards a concurrent push without counting it as an overflow.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign ovf_set = push & ~flush & full & ~do_pop;

  // Next pointer/count state; flush overrides any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hid_event_hub.sv
// Multi-channel HID event hub: per-channel FIFOs behind a 64-bit word-addressed bus window.
// Optional feature macro: HID_IRQ_EN builds the CTRL irq-enable register and the level interrupt;
// without it CTRL reads 0 and hid_irq is tied low.
module hid_event_hub
  import hid_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int DEPTH = 16
) (
  input  logic               msoc_clk,
  input  logic               rst,
  input  logic [NCHAN-1:0]   scan_ready,
  input  logic [8*NCHAN-1:0] scan_code,
  input  logic [NCHAN-1:0]   scan_released,
  input  logic               hid_en,
  input  logic [7:0]         hid_be,
  input  logic [7:0]         hid_addr,
  input  logic [63:0]        hid_wrdata,
  output logic [63:0]        hid_rddata,
  output logic               hid_irq
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]                  word;
  logic                        rd_acc, wr_acc;
  logic [NCHAN-1:0]            scan_ready_q, scan_ready_d;
  logic [NCHAN-1:0]            push, pop, flush, ovf_clr, ovf_set;
  logic [NCHAN-1:0]            empty, full;
  logic [NCHAN-1:0]            ovf_q, ovf_d;
  logic [NCHAN-1:0]            ie;
  hid_event_t [NCHAN-1:0]      din, dout;
  logic [NCHAN-1:0][CW-1:0]    count;
  logic [63:0]                 rd_word;
  logic [63:0]                 rddata_q, rddata_d;
  logic                        unused_ok;

  assign word   = hid_addr[7:3];
  assign rd_acc = hid_en && (hid_be == 8'h00);
  assign wr_acc = hid_en && (hid_be != 8'h00);
  assign push   = scan_ready & ~scan_ready_q;
  assign scan_ready_d = scan_ready;
  assign hid_rddata   = rddata_q;
  assign unused_ok    = ^{hid_addr[2:0], hid_wrdata};

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    localparam logic [4:0] W_DATA = 5'(WORDS_PER_CHAN * gi + WORD_DATA_OFS);
    localparam logic [4:0] W_STAT = 5'(WORDS_PER_CHAN * gi + WORD_STATUS_OFS);

    assign din[gi]     = {scan_released[gi], scan_code[8*gi +: 8]};
    assign pop[gi]     = rd_acc && (word == W_DATA) && !empty[gi];
    assign flush[gi]   = wr_acc && (word == W_STAT) && hid_be[2] && hid_wrdata[STAT_FLUSH_BIT];
    assign ovf_clr[gi] = wr_acc && (word == W_STAT) && hid_be[2] && hid_wrdata[STAT_OVF_BIT];

    hid_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (msoc_clk),
      .srst    (rst),
      .push    (push[gi]),
      .pop     (pop[gi]),
      .flush   (flush[gi]),
      .din     (din[gi]),
      .dout    (dout[gi]),
      .count   (count[gi]),
      .empty   (empty[gi]),
      .full    (full[gi]),
      .ovf_set (ovf_set[gi])
    );
  end

  // Sticky overflow: a same-cycle set beats the W1C clear.
  assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

  // Read mux over the word map; the read register only loads on a read access.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (word == 5'(WORDS_PER_CHAN * c + WORD_DATA_OFS) && !empty[c]) begin
        rd_word[DATA_VALID_BIT] = 1'b1;
        rd_word[8:0]            = dout[c];
      end
      if (word == 5'(WORDS_PER_CHAN * c + WORD_STATUS_OFS)) begin
        rd_word[15:0]          = 16'(count[c]);
        rd_word[STAT_EMPTY_BIT] = empty[c];
        rd_word[STAT_FULL_BIT]  = full[c];
        rd_word[STAT_OVF_BIT]   = ovf_q[c];
      end
    end
    if (word == 5'(ctrl_word(NCHAN))) rd_word[NCHAN-1:0] = ie;
    rddata_d = rd_acc ? rd_word : rddata_q;
  end

  // Edge-detect history, overflow flags and read-data register.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      scan_ready_q <= '0;
      ovf_q        <= '0;
      rddata_q     <= '0;
    end else begin
      scan_ready_q <= scan_ready_d;
      ovf_q        <= ovf_d;
      rddata_q     <= rddata_d;
    end
  end

`ifdef HID_IRQ_EN
  logic [NCHAN-1:0] ie_q, ie_d;
  logic             irq_q, irq_d;

  // CTRL irq-enable write and level interrupt from enabled non-empty channels.
  always_comb begin
    ie_d = ie_q;
    if (wr_acc && (word == 5'(ctrl_word(NCHAN))) && hid_be[0]) ie_d = hid_wrdata[NCHAN-1:0];
    irq_d = |(ie_q & ~empty);
  end

  // Interrupt enable and registered interrupt output.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie      = ie_q;
  assign hid_irq = irq_q;
`else
  assign ie      = '0;
  assign hid_irq = 1'b0;
`endif

endmodule

// File: tb/tb_hid_event_hub.sv
// Directed self-checking bench for hid_event_hub (NCHAN=2, DEPTH=16).
module tb_hid_event_hub;

  logic        msoc_clk;
  logic        rst;
  logic [1:0]  scan_ready;
  logic [15:0] scan_code;
  logic [1:0]  scan_released;
  logic        hid_en;
  logic [7:0]  hid_be;
  logic [7:0]  hid_addr;
  logic [63:0] hid_wrdata;
  logic [63:0] hid_rddata;
  logic        hid_irq;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] A_DATA0 = 8'h00;
  localparam logic [7:0] A_STAT0 = 8'h08;
  localparam logic [7:0] A_DATA1 = 8'h10;
  localparam logic [7:0] A_STAT1 = 8'h18;
  localparam logic [7:0] A_CTRL  = 8'h20;
  localparam logic [7:0] A_NONE  = 8'h28;

`ifdef HID_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
  localparam logic [63:0] CTRL_EXP = 64'h2;
`else
  localparam logic IRQ_ON = 1'b0;
  localparam logic [63:0] CTRL_EXP = 64'h0;
`endif

  hid_event_hub #(.NCHAN(2), .DEPTH(16)) dut (
    .msoc_clk      (msoc_clk),
    .rst           (rst),
    .scan_ready    (scan_ready),
    .scan_code     (scan_code),
    .scan_released (scan_released),
    .hid_en        (hid_en),
    .hid_be        (hid_be),
    .hid_addr      (hid_addr),
    .hid_wrdata    (hid_wrdata),
    .hid_rddata    (hid_rddata),
    .hid_irq       (hid_irq)
  );

  initial begin
    msoc_clk = 1'b0;
    forever #5 msoc_clk = ~msoc_clk;
  end

  task automatic tick();
    @(posedge msoc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input logic [7:0] addr);
    hid_en = 1'b1; hid_be = 8'h00; hid_addr = addr;
    tick();
    hid_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] be, input logic [63:0] data);
    hid_en = 1'b1; hid_be = be; hid_addr = addr; hid_wrdata = data;
    tick();
    hid_en = 1'b0; hid_be = 8'h00; hid_wrdata = '0;
  endtask

  task automatic pulse(input int c, input logic [7:0] code, input logic rel);
    scan_code[8*c +: 8] = code;
    scan_released[c]    = rel;
    scan_ready[c]       = 1'b1;
    tick();
    scan_ready[c] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; scan_ready = '0; scan_code = '0; scan_released = '0;
    hid_en = 1'b0; hid_be = '0; hid_addr = '0; hid_wrdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_irq", {63'd0, hid_irq}, 64'h0);
    check("rst_rddata", hid_rddata, 64'h0);
    rd(A_DATA0); check("rst_data0", hid_rddata, 64'h0);
    rd(A_STAT0); check("rst_stat0", hid_rddata, 64'h1_0000);
    rd(A_DATA1); check("rst_data1", hid_rddata, 64'h0);
    rd(A_STAT1); check("rst_stat1", hid_rddata, 64'h1_0000);
    rd(A_CTRL);  check("rst_ctrl", hid_rddata, 64'h0);
    rd(A_NONE);  check("rst_unmap", hid_rddata, 64'h0);

    // Two events on channel 0, drained in order, then an empty read
    pulse(0, 8'h1C, 1'b0);
    pulse(0, 8'hF0, 1'b1);
    rd(A_STAT0); check("stat0_cnt2", hid_rddata, 64'h2);
    rd(A_DATA0); check("data0_1c", hid_rddata, 64'h8000_0000_0000_001C);
    rd(A_DATA0); check("data0_f0", hid_rddata, 64'h8000_0000_0000_01F0);
    rd(A_DATA0); check("data0_empty", hid_rddata, 64'h0);
    rd(A_STAT0); check("stat0_empty", hid_rddata, 64'h1_0000);

    // Overfill channel 1, then W1C the overflow flag
    for (int i = 0; i < 17; i++) pulse(1, 8'(i), 1'b0);
    rd(A_STAT1); check("stat1_ovf", hid_rddata, 64'h6_0010);
    wr(A_STAT1, 8'h04, 64'h4_0000);
    check("rddata_hold", hid_rddata, 64'h6_0010);
    rd(A_STAT1); check("stat1_w1c", hid_rddata, 64'h2_0010);

    // Push and pop together on a full FIFO
    scan_code[15:8] = 8'h55; scan_released[1] = 1'b0; scan_ready[1] = 1'b1;
    rd(A_DATA1);
    scan_ready[1] = 1'b0;
    check("full_pp_data", hid_rddata, 64'h8000_0000_0000_0000);
    rd(A_STAT1); check("full_pp_stat", hid_rddata, 64'h2_0010);
    rd(A_DATA1); check("full_pp_head", hid_rddata, 64'h8000_0000_0000_0001);

    // Flush channel 1
    wr(A_STAT1, 8'h04, 64'h10_0000);
    rd(A_STAT1); check("flush1", hid_rddata, 64'h1_0000);

    // Interrupt enable on channel 1 only
    wr(A_CTRL, 8'h01, 64'h2);
    rd(A_CTRL); check("ctrl_rd", hid_rddata, CTRL_EXP);
    scan_code[15:8] = 8'h77; scan_ready[1] = 1'b1;
    tick();
    scan_ready[1] = 1'b0;
    check("irq_n1", {63'd0, hid_irq}, 64'h0);
    tick();
    check("irq_n2", {63'd0, hid_irq}, {63'd0, IRQ_ON});
    rd(A_DATA1);
    check("irq_data1", hid_rddata, 64'h8000_0000_0000_0077);
    check("irq_at_pop", {63'd0, hid_irq}, {63'd0, IRQ_ON});
    tick();
    check("irq_clear", {63'd0, hid_irq}, 64'h0);
    pulse(0, 8'h33, 1'b0);
    tick();
    check("irq_ch0_off", {63'd0, hid_irq}, 64'h0);
    rd(A_DATA0); check("drain0", hid_rddata, 64'h8000_0000_0000_0033);

    // Reset during a DATA read
    pulse(0, 8'h11, 1'b0);
    pulse(0, 8'h22, 1'b0);
    pulse(0, 8'h33, 1'b0);
    rst = 1'b1;
    rd(A_DATA0);
    rst = 1'b0;
    check("rst_mid_rd", hid_rddata, 64'h0);
    rd(A_STAT0); check("rst_mid_stat", hid_rddata, 64'h1_0000);

    // Flush and push in the same cycle
    pulse(0, 8'h44, 1'b0);
    scan_code[7:0] = 8'h45; scan_ready[0] = 1'b1;
    wr(A_STAT0, 8'h04, 64'h10_0000);
    scan_ready[0] = 1'b0;
    rd(A_STAT0); check("flush_push", hid_rddata, 64'h1_0000);

    // Overflow set and W1C clear in the same cycle
    for (int i = 0; i < 16; i++) pulse(1, 8'(i + 8'h80), 1'b0);
    scan_code[15:8] = 8'hEE; scan_ready[1] = 1'b1;
    wr(A_STAT1, 8'h04, 64'h4_0000);
    scan_ready[1] = 1'b0;
    rd(A_STAT1); check("ovf_set_wins", hid_rddata, 64'h6_0010);
    rd(A_DATA1); check("ovf_head", hid_rddata, 64'h8000_0000_0000_0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
